// File: rtl/mips_program_loader_if.sv
// -----------------------------------------------------------------------------
// mips_program_loader_if
//   Groups the byte-stream handshake and the instruction-ROM write bus that the
//   program loader sits between.
//
//   in_valid / in_data / in_ready : byte stream into the loader (valid/ready)
//   rom_wr_en / rom_wr_addr / rom_wr_data : word writes into instruction memory
//
//   Modports:
//     master : the stream source / environment side
//     slave  : the loader itself
// -----------------------------------------------------------------------------
interface mips_program_loader_if #(
  parameter int ADDR_W = 6
);
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              rom_wr_en;
  logic [ADDR_W-1:0] rom_wr_addr;
  logic [31:0]       rom_wr_data;

  modport master (
    output in_valid, in_data,
    input  in_ready, rom_wr_en, rom_wr_addr, rom_wr_data
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, rom_wr_en, rom_wr_addr, rom_wr_data
  );
endinterface

// File: rtl/mips_program_loader.sv
// -----------------------------------------------------------------------------
// mips_program_loader
//   Receives a program image as a byte stream, assembles big-endian 32-bit
//   words, writes them sequentially into instruction memory and releases the
//   CPU from reset only once the whole image has loaded with a good checksum.
//
//   Image format: 4-byte word count N (MSB first), N*4 data bytes (each word
//   MSB first), 1 checksum byte. The 8-bit wrap-around sum of every byte,
//   checksum included, must be zero.
//
//   Ports:
//     clk      : clock, all state updates on the rising edge
//     rst_n    : asynchronous active-low reset
//     restart  : synchronous pulse, returns to the header state from anywhere
//     bus      : stream handshake + ROM write bus (slave modport)
//     cpu_hold : holds the CPU in reset while high
//     done     : image loaded and verified
//     error    : image rejected (bad length or bad checksum)
// -----------------------------------------------------------------------------
module mips_program_loader #(
  parameter int ADDR_L = 64,
  parameter int ADDR_W = $clog2(ADDR_L)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  restart,
  mips_program_loader_if.slave  bus,
  output logic                  cpu_hold,
  output logic                  done,
  output logic                  error
);

  localparam logic [2:0] ST_HDR  = 3'd0;
  localparam logic [2:0] ST_DATA = 3'd1;
  localparam logic [2:0] ST_CHK  = 3'd2;
  localparam logic [2:0] ST_DONE = 3'd3;
  localparam logic [2:0] ST_ERR  = 3'd4;

  logic [2:0]        state;
  logic [1:0]        byte_idx;
  logic [ADDR_W:0]   word_cnt;   // one extra bit so N == ADDR_L fits
  logic [ADDR_W:0]   n_words;
  logic [7:0]        sum;
  logic [23:0]       shift_reg;  // first three bytes of the header or word
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;

  logic              xfer;
  logic [31:0]       full_word;
  logic [ADDR_W:0]   word_cnt_inc;
  logic [7:0]        sum_chk;

  // Ready depends only on state, so the source never sees a combinational
  // path from its own valid.
  assign bus.in_ready = (state == ST_HDR) || (state == ST_DATA) || (state == ST_CHK);
  assign xfer         = bus.in_valid && bus.in_ready;
  assign full_word    = {shift_reg, bus.in_data};
  assign word_cnt_inc = word_cnt + 1'b1;
  assign sum_chk      = sum + bus.in_data;

  assign bus.rom_wr_en   = wr_en;
  assign bus.rom_wr_addr = wr_addr;
  assign bus.rom_wr_data = wr_data;

  // NOTE: every register here is assigned with <= so all updates land together
  // at the clock edge; blocking '=' would let later lines see half-updated state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_HDR;
      byte_idx  <= '0;
      word_cnt  <= '0;
      n_words   <= '0;
      sum       <= '0;
      shift_reg <= '0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      cpu_hold  <= 1'b1;
      done      <= 1'b0;
      error     <= 1'b0;
    end else begin
      // The strobe is a single-cycle pulse; any strobe already on the bus
      // this cycle completes regardless of restart.
      wr_en <= 1'b0;

      if (restart) begin
        // Restart wins over a concurrent transfer: the byte is not consumed.
        state     <= ST_HDR;
        byte_idx  <= '0;
        word_cnt  <= '0;
        n_words   <= '0;
        sum       <= '0;
        shift_reg <= '0;
        wr_addr   <= '0;
        wr_data   <= '0;
        cpu_hold  <= 1'b1;
        done      <= 1'b0;
        error     <= 1'b0;
      end else if (xfer) begin
        unique case (state)
          ST_HDR: begin
            sum       <= sum_chk;
            shift_reg <= full_word[23:0];
            byte_idx  <= byte_idx + 1'b1;
            if (byte_idx == 2'd3) begin
              // Judge the full 32-bit count so large values cannot alias
              // into the legal range.
              if (full_word == 32'd0 || full_word > 32'(ADDR_L)) begin
                state <= ST_ERR;
                error <= 1'b1;
              end else begin
                state    <= ST_DATA;
                word_cnt <= '0;
                n_words  <= full_word[ADDR_W:0];
              end
            end
          end

          ST_DATA: begin
            sum       <= sum_chk;
            shift_reg <= full_word[23:0];
            byte_idx  <= byte_idx + 1'b1;
            if (byte_idx == 2'd3) begin
              wr_en    <= 1'b1;
              wr_addr  <= word_cnt[ADDR_W-1:0];
              wr_data  <= full_word;
              word_cnt <= word_cnt_inc;
              if (word_cnt_inc == n_words) state <= ST_CHK;
            end
          end

          ST_CHK: begin
            if (sum_chk == 8'd0) begin
              state    <= ST_DONE;
              done     <= 1'b1;
              cpu_hold <= 1'b0;
            end else begin
              state <= ST_ERR;
              error <= 1'b1;
            end
          end

          default: ; // DONE / ERR never assert ready, so no transfer arrives
        endcase
      end
    end
  end

endmodule
